// File: rtl/dsp_accum_if.sv
// Stream bundle for dsp_accum: product input stream with bias, and result output stream.
// The slave modport is the accumulator's view; master is the surrounding environment.
interface dsp_accum_if #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 10
);
  logic [ACC_WIDTH-1:0] bias;
  logic [IN_WIDTH-1:0]  input_tdata;
  logic                 input_tvalid;
  logic                 input_tready;
  logic                 input_tlast;
  logic [OUT_WIDTH-1:0] output_tdata;
  logic                 output_tvalid;
  logic                 output_tready;
  logic                 output_sat;
  logic [CNT_WIDTH-1:0] output_count;

  modport slave (
    input  bias, input_tdata, input_tvalid, input_tlast, output_tready,
    output input_tready, output_tdata, output_tvalid, output_sat, output_count
  );

  modport master (
    output bias, input_tdata, input_tvalid, input_tlast, output_tready,
    input  input_tready, output_tdata, output_tvalid, output_sat, output_count
  );
endinterface

// File: rtl/dsp_accum.sv
// Dot-product accumulator: saturating sum of signed products plus bias, rescaled by an
// arithmetic right shift and saturated to the output width, one result per tlast.
module dsp_accum #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 7,
  parameter int CNT_WIDTH = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  dsp_accum_if.slave   bus
);

  typedef enum logic {S_FIRST, S_ACCUM} state_t;

  localparam int HI_W = ACC_WIDTH - OUT_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 sat_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic                 out_sat_q;
  logic [CNT_WIDTH-1:0] out_count_q;
  logic                 out_valid_q;

  logic                 first;
  logic                 in_ready;
  logic                 accept;
  logic                 xfer;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 acc_sat;
  logic [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] scaled;
  logic [HI_W-1:0]      hi;
  logic                 out_ovf;
  logic [OUT_WIDTH-1:0] out_next;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 sat_next;

  assign first    = (state_q == S_FIRST);
  assign in_ready = ~out_valid_q | bus.output_tready;
  assign accept   = bus.input_tvalid & in_ready;
  assign xfer     = out_valid_q & bus.output_tready;

  always_comb begin
    base     = first ? bus.bias : acc_q;
    // One guard bit: overflow shows up as the top two bits disagreeing.
    sum_wide = {base[ACC_WIDTH-1], base}
             + {{(ACC_WIDTH+1-IN_WIDTH){bus.input_tdata[IN_WIDTH-1]}}, bus.input_tdata};
    acc_sat  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    acc_next = acc_sat ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_WIDTH-1:0];
    scaled   = $signed(acc_next) >>> SHIFT;
    // Fits the output only if every bit above the output sign bit matches it.
    hi       = scaled[ACC_WIDTH-1:OUT_WIDTH-1];
    out_ovf  = (hi != '0) && (hi != '1);
    out_next = out_ovf ? (scaled[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX) : scaled[OUT_WIDTH-1:0];
    count_next = first ? CNT_WIDTH'(1) : count_q + CNT_WIDTH'(1);
    sat_next   = (~first & sat_q) | acc_sat;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = bus.input_tlast ? S_FIRST : S_ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FIRST;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (xfer) out_valid_q <= 1'b0;
      if (accept) begin
        acc_q   <= acc_next;
        count_q <= count_next;
        sat_q   <= sat_next;
        if (bus.input_tlast) begin
          out_data_q  <= out_next;
          out_sat_q   <= sat_next | out_ovf;
          out_count_q <= count_next;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.input_tready  = in_ready;
  assign bus.output_tdata  = out_data_q;
  assign bus.output_tvalid = out_valid_q;
  assign bus.output_sat    = out_sat_q;
  assign bus.output_count  = out_count_q;

endmodule

// File: doc/dsp_accum.md
Name: dsp_accum

Overview:
- Downstream consumer of the DSP multiplier stage. Accumulates a stream of signed products into one neuron dot-product, adding a bias term.
- At the end of each vector (tlast), rescales the sum by an arithmetic right shift, saturates it to the output width, and emits one result beat.
- Input and output are AXI-stream style. The block is fully pipelined: back-to-back vectors run with no bubble.

Parameters:
- IN_WIDTH, 16: product width; matches the multiplier output (2*WIDTH).
- ACC_WIDTH, 32: accumulator width; must be >= IN_WIDTH.
- OUT_WIDTH, 16: result width; must be <= ACC_WIDTH.
- SHIFT, 7: fixed-point rescale, arithmetic right shift applied before output saturation.
- CNT_WIDTH, 10: width of the term counter.

Ports:
- clk input 1: clock, rising edge.
- rst_n input 1: asynchronous active-low reset.
- bias input ACC_WIDTH: signed bias; sampled on the first accepted beat of each vector.
- input_tdata input IN_WIDTH: signed product.
- input_tvalid input 1: product valid.
- input_tready output 1: block can accept a product.
- input_tlast input 1: marks the last product of the vector.
- output_tdata output OUT_WIDTH: signed rescaled, saturated result.
- output_tvalid output 1: result valid.
- output_tready input 1: downstream accepts the result.
- output_sat output 1: saturation occurred in this vector (accumulator or output); qualified by output_tvalid.
- output_count output CNT_WIDTH: number of terms in this vector, qualified by output_tvalid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc, count, sat_sticky, output_tdata, output_sat and output_count all cleared to 0.
  - output_tvalid = 0; first flag = 1.
  - A reset in mid-vector discards the partial sum; the next accepted beat starts a new vector.
- Handshake:
  - input_tready = ~output_tvalid | output_tready (combinational).
  - A beat is accepted when input_tvalid & input_tready.
  - An output transfer occurs when output_tvalid & output_tready.
- Sum path, per accepted beat:
  - base = first ? bias : acc.
  - sum = base + sign-extended input_tdata, computed at ACC_WIDTH+1 bits.
  - If sum exceeds the signed ACC_WIDTH range, clamp to +max or -min and flag saturation.
  - acc <= clamped sum. count <= first ? 1 : count+1, wrapping at 2^CNT_WIDTH. sat_sticky <= (first ? 0 : sat_sticky) | acc_sat.
- Non-last beat: first <= 0.
- Last beat (input_tlast = 1): in the same clock edge:
  - output_tdata <= clamp_OUT(clamped_sum >>> SHIFT).
  - output_sat <= sticky OR this beat's acc_sat OR output-clamp.
  - output_count <= new count.
  - output_tvalid <= 1; first <= 1.
- Latency: output_tvalid rises on the clock edge that accepts the tlast beat, i.e. valid in the cycle after the tlast handshake.
- Single-beat vector (first and tlast together): result = clamp(bias + in), count = 1.
- Output register:
  - output_tvalid clears on an output transfer unless a new tlast beat is accepted in the same cycle, in which case the new result loads and valid stays 1.
  - output_tdata and the other result fields are held stable while output_tvalid = 1 and output_tready = 0.
  - While the result is held, input_tready = 0 and accumulation pauses; acc and count are unchanged.
- Rounding: truncation toward -inf (plain arithmetic shift). No rounding.
- A non-last beat may be accepted while an earlier result is still pending, provided output_tready = 1 in that cycle.

Test Plan:
- Bench settings for all cases: SHIFT=0 unless stated, OUT_WIDTH=16, ACC_WIDTH=32.
- Basic vector: bias=10; beats 3, -5, 7 (tlast on 7); output_tready=1 -> one output beat: tdata=15, count=3, sat=0. tvalid is high exactly one cycle after the tlast handshake.
- Rescale: SHIFT=7, bias=0; beats 256 and -1 (last) -> sum 255 >>> 7 = 1. Then beat -129 (single beat) -> -2, confirming floor behaviour.
- Saturation: bias=0; beats 30000, 30000 (last) -> tdata=32767, sat=1. Next vector -40000+... is out of IN_WIDTH range, so use bias=-40000 with beat 0 (last) -> tdata=-32768, sat=1. A following clean vector gives sat=0.
- Backpressure: hold output_tready=0 after a result -> input_tready=0 and tdata stable for 5 cycles. Release -> the result is accepted, and back-to-back vectors (tlast every 2 beats) then stream with no idle cycle.
- Reset mid-vector: accept 2 beats, pulse rst_n low asynchronously between clock edges -> tvalid=0 immediately. Next vector bias=1, beat 1 (last) -> tdata=2, count=1.
